// File: rtl/clk_div_prog.sv
// Runtime-programmable clock/tick divider with shadowed divisor/mode settings.
// New settings take effect only at a period boundary or while counting is disabled.
module clk_div_prog #(
    parameter int unsigned     WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DIV = 8'd14,
    parameter logic            RESET_MODE = 1'b0
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEn,
    input  logic             iClr,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] ivDiv,
    input  logic             iMode,
    output logic             oClkDiv,
    output logic             oTick,
    output logic             oPending,
    output logic [WIDTH-1:0] ovCnt
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO  = {{(WIDTH-2){1'b0}}, 2'b10};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_div_q, act_div_d;
    logic             act_mode_q, act_mode_d;
    logic [WIDTH-1:0] sh_div_q, sh_div_d;
    logic             sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_div_q, clk_div_d;

    logic [WIDTH-1:0] neff;
    logic [WIDTH-1:0] neff_m1;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;
    logic             wrap;

    // Clamp the divisor so N=0 (and N=1 in square mode) still gives a valid period.
    always_comb begin
        neff = act_div_q;
        if (act_mode_q) begin
            if (act_div_q < TWO) neff = TWO;
        end else begin
            if (act_div_q == ZERO) neff = ONE;
        end
    end

    // ceil(neff/2) without forming neff+1, so the all-ones divisor cannot overflow.
    assign half    = (neff >> 1) + {{(WIDTH-1){1'b0}}, neff[0]};
    assign neff_m1 = neff - ONE;
    assign cnt_inc = cnt_q + ONE;
    assign wrap    = (cnt_q == neff_m1);

    always_comb begin
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        act_mode_d = act_mode_q;
        sh_div_d   = sh_div_q;
        sh_mode_d  = sh_mode_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        clk_div_d  = clk_div_q;

        if (iClr) begin
            cnt_d     = ZERO;
            clk_div_d = 1'b0;
        end else if (iEn) begin
            if (wrap) begin
                // Next count is 0, which is below half in square mode and a tick in pulse mode.
                cnt_d     = ZERO;
                tick_d    = 1'b1;
                clk_div_d = 1'b1;
                if (pend_q) begin
                    act_div_d  = sh_div_q;
                    act_mode_d = sh_mode_q;
                    pend_d     = 1'b0;
                end
            end else begin
                cnt_d     = cnt_inc;
                clk_div_d = act_mode_q ? (cnt_inc < half) : 1'b0;
            end
        end else if (pend_q) begin
            act_div_d  = sh_div_q;
            act_mode_d = sh_mode_q;
            pend_d     = 1'b0;
            cnt_d      = ZERO;
        end

        // A capture in the same cycle as an apply lands in the shadow and waits for the next one.
        if (iLoad) begin
            sh_div_d  = ivDiv;
            sh_mode_d = iMode;
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q      <= ZERO;
            act_div_q  <= RESET_DIV;
            act_mode_q <= RESET_MODE;
            sh_div_q   <= RESET_DIV;
            sh_mode_q  <= RESET_MODE;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            clk_div_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            act_mode_q <= act_mode_d;
            sh_div_q   <= sh_div_d;
            sh_mode_q  <= sh_mode_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            clk_div_q  <= clk_div_d;
        end
    end

    assign oClkDiv  = clk_div_q;
    assign oTick    = tick_q;
    assign oPending = pend_q;
    assign ovCnt    = cnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a vector table for the mid-period load
// plus hand-written sequences for mode, degenerate divisor, enable/clear and reset cases.
module tb_clk_div_prog;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] div;
    logic       mode;
    logic       clk_div;
    logic       tick;
    logic       pend;
    logic [7:0] cnt;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       en;
        logic       clr;
        logic       load;
        logic [7:0] div;
        logic       mode;
        logic [7:0] e_cnt;
        logic       e_tick;
        logic       e_clk;
        logic       e_pend;
    } vec_t;

    vec_t tbl[$];

    clk_div_prog #(
        .WIDTH(8),
        .RESET_DIV(8'd14),
        .RESET_MODE(1'b0)
    ) dut (
        .iClk(clk),
        .iRst_n(rst_n),
        .iEn(en),
        .iClr(clr),
        .iLoad(load),
        .ivDiv(div),
        .iMode(mode),
        .oClkDiv(clk_div),
        .oTick(tick),
        .oPending(pend),
        .ovCnt(cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // driver tasks
    task automatic step(input logic e, input logic c, input logic l,
                        input logic [7:0] d, input logic m);
        en   = e;
        clr  = c;
        load = l;
        div  = d;
        mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en    = 1'b0;
        clr   = 1'b0;
        load  = 1'b0;
        div   = 8'd0;
        mode  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(input int max_cycles, input string name);
        int i;
        i = 0;
        while (tick !== 1'b1 && i < max_cycles) begin
            @(posedge clk);
            #1;
            i++;
        end
        check(name, tick, 1);
    endtask

    function automatic void add(input logic e, input logic c, input logic l,
                                input logic [7:0] d, input logic m,
                                input logic [7:0] ec, input logic et,
                                input logic ek, input logic ep);
        vec_t v;
        v.en = e; v.clr = c; v.load = l; v.div = d; v.mode = m;
        v.e_cnt = ec; v.e_tick = et; v.e_clk = ek; v.e_pend = ep;
        tbl.push_back(v);
    endfunction

    initial begin
        int highs;

        // Mid-period load table: N=14 active, load N=4 while ovCnt=6.
        for (int i = 1; i <= 6; i++) add(1, 0, 0, 8'd0, 0, 8'(i), 0, 0, 0);
        add(1, 0, 1, 8'd4, 0, 8'd7, 0, 0, 1);
        for (int i = 8; i <= 13; i++) add(1, 0, 0, 8'd0, 0, 8'(i), 0, 0, 1);
        add(1, 0, 0, 8'd0, 0, 8'd0, 1, 1, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 3; i++) add(1, 0, 0, 8'd0, 0, 8'(i), 0, 0, 0);
            add(1, 0, 0, 8'd0, 0, 8'd0, 1, 1, 0);
        end

        en = 1'b0; clr = 1'b0; load = 1'b0; div = 8'd0; mode = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_cnt", cnt, 0);
        check("rst_tick", tick, 0);
        check("rst_clk", clk_div, 0);
        check("rst_pend", pend, 0);

        // Defaults: divide by 14, pulse mode.
        do_reset();
        for (int i = 1; i <= 28; i++) begin
            step(1, 0, 0, 8'd0, 0);
            check("def_cnt", cnt, i % 14);
            check("def_tick", tick, (i % 14) == 0);
            check("def_clk", clk_div, (i % 14) == 0);
            check("def_pend", pend, 0);
        end

        // Vector table.
        do_reset();
        foreach (tbl[k]) begin
            step(tbl[k].en, tbl[k].clr, tbl[k].load, tbl[k].div, tbl[k].mode);
            check("tbl_cnt", cnt, tbl[k].e_cnt);
            check("tbl_tick", tick, tbl[k].e_tick);
            check("tbl_clk", clk_div, tbl[k].e_clk);
            check("tbl_pend", pend, tbl[k].e_pend);
        end

        // Square mode, N=5: 1,1,1,0,0.
        do_reset();
        step(1, 0, 1, 8'd5, 1);
        check("sq5_pend", pend, 1);
        check("sq5_cnt", cnt, 1);
        step(1, 0, 0, 8'd0, 0);
        wait_tick(20, "sq5_wrap");
        check("sq5_pend_clr", pend, 0);
        check("sq5_wrap_clk", clk_div, 1);
        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 0, 8'd0, 0);
            check("sq5_cnt", cnt, k % 5);
            check("sq5_clk", clk_div, (k % 5) < 3);
            check("sq5_tick", tick, (k % 5) == 0);
        end

        // Square mode, N=1: toggles every cycle.
        step(1, 0, 1, 8'd1, 1);
        check("sq1_pend", pend, 1);
        step(1, 0, 0, 8'd0, 0);
        wait_tick(10, "sq1_wrap");
        check("sq1_pend_clr", pend, 0);
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, 0, 8'd0, 0);
            check("sq1_clk", clk_div, (k % 2) == 0);
            check("sq1_tick", tick, (k % 2) == 0);
        end

        // Square mode, N=255: 128 high, 127 low.
        step(1, 0, 1, 8'd255, 1);
        check("sq255_clk0", clk_div, 0);
        step(1, 0, 0, 8'd0, 0);
        wait_tick(5, "sq255_wrap");
        highs = int'(clk_div);
        for (int k = 1; k <= 254; k++) begin
            step(1, 0, 0, 8'd0, 0);
            highs += int'(clk_div);
            if (k == 127) check("sq255_last_high", clk_div, 1);
            if (k == 128) check("sq255_first_low", clk_div, 0);
        end
        check("sq255_highs", highs, 128);
        step(1, 0, 0, 8'd0, 0);
        check("sq255_tick", tick, 1);
        check("sq255_cnt", cnt, 0);

        // Pulse mode, N=0 then N=1: tick constantly high.
        step(1, 0, 1, 8'd0, 0);
        check("p0_tick0", tick, 0);
        check("p0_pend", pend, 1);
        step(1, 0, 0, 8'd0, 0);
        wait_tick(300, "p0_wrap");
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0, 8'd0, 0);
            check("p0_tick", tick, 1);
            check("p0_cnt", cnt, 0);
            check("p0_clk", clk_div, 1);
        end
        step(1, 0, 1, 8'd1, 0);
        check("p1_tick_ld", tick, 1);
        check("p1_pend_ld", pend, 1);
        step(1, 0, 0, 8'd0, 0);
        check("p1_pend_clr", pend, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 8'd0, 0);
            check("p1_tick", tick, 1);
        end

        // Enable hold, then clear.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 0, 8'd0, 0);
        check("en_cnt7", cnt, 7);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 8'd0, 0);
            check("dis_cnt", cnt, 7);
            check("dis_tick", tick, 0);
        end
        step(1, 0, 0, 8'd0, 0);
        check("reen_cnt", cnt, 8);
        step(1, 1, 0, 8'd0, 0);
        check("clr_cnt", cnt, 0);
        check("clr_tick", tick, 0);
        check("clr_clk", clk_div, 0);
        for (int i = 1; i <= 14; i++) begin
            step(1, 0, 0, 8'd0, 0);
            check("postclr_cnt", cnt, i % 14);
            check("postclr_tick", tick, i == 14);
        end

        // Load while disabled: applied next cycle with count restarted.
        step(1, 0, 0, 8'd0, 0);
        step(1, 0, 0, 8'd0, 0);
        check("dl_cnt2", cnt, 2);
        step(0, 0, 1, 8'd3, 0);
        check("dl_pend", pend, 1);
        check("dl_hold", cnt, 2);
        step(0, 0, 0, 8'd0, 0);
        check("dl_pend_clr", pend, 0);
        check("dl_cnt0", cnt, 0);
        for (int i = 1; i <= 6; i++) begin
            step(1, 0, 0, 8'd0, 0);
            check("dl3_cnt", cnt, i % 3);
            check("dl3_tick", tick, (i % 3) == 0);
        end

        // Async reset with a load pending.
        do_reset();
        step(1, 0, 1, 8'd6, 0);
        check("ar_pend", pend, 1);
        step(1, 0, 0, 8'd0, 0);
        step(1, 0, 0, 8'd0, 0);
        check("ar_cnt3", cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_cnt", cnt, 0);
        check("ar_tick", tick, 0);
        check("ar_clk", clk_div, 0);
        check("ar_pend_clr", pend, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step(1, 0, 0, 8'd0, 0);
            check("ar_tick14", tick, i == 14);
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
